glyph_renderer: RTL

Walks one 8×16 character glyph, drives the registered 1-bit glyph ROM address, and turns each returned bit into a coloured, addressed pixel for the TFT pixel writer. It sits between the text/digit controller upstream, which issues one render request per character, and the TFT write path downstream. Throughput is one pixel per cycle under full backpressure-free operation.

---
 rtl/tft_char_pkg.sv | 23 ++
 rtl/glyph_pix_fifo.sv | 60 ++++++
 rtl/glyph_renderer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tft_char_pkg.sv
// Shared constants, types and FSM encoding for the character/glyph TFT path.
package tft_char_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW  = 7;

    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(GLYPH_W * GLYPH_H - 1);

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } glyph_state_t;

    function automatic rgb565_t pick_color(input logic bit_in, input rgb565_t fg, input rgb565_t bg);
        return bit_in ? fg : bg;
    endfunction

endpackage

// File: rtl/glyph_pix_fifo.sv
// Two-entry valid/ready pixel FIFO; the occupancy count feeds the issue credit check.
module glyph_pix_fifo #(
    parameter int W = 34
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = (r_count != 2'd0) && i_ready;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge i_clock) begin
                if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/glyph_renderer.sv
// Walks an 8x16 glyph through a 1-cycle registered ROM and emits addressed,
// coloured pixels through a credit-limited 2-entry output FIFO.
module glyph_renderer
    import tft_char_pkg::*;
#(
    parameter int X_W = 9,
    parameter int Y_W = 9
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [3:0]        i_char_code,
    input  logic [X_W-1:0]    i_pos_x,
    input  logic [Y_W-1:0]    i_pos_y,
    input  rgb565_t           i_fg_color,
    input  rgb565_t           i_bg_color,
    input  logic              i_opaque,
    output logic              o_busy,
    output logic              o_done,
    output logic [3:0]        o_rom_sel,
    output logic [ROM_AW-1:0] o_rom_address,
    input  logic              i_rom_q,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [X_W-1:0]    o_pix_x,
    output logic [Y_W-1:0]    o_pix_y,
    output rgb565_t           o_pix_color
);

    localparam int ENT_W = X_W + Y_W + 16;

    glyph_state_t      r_state;
    glyph_state_t      w_state_next;
    logic [ROM_AW-1:0] r_idx;
    logic [ROM_AW-1:0] r_if_idx;
    logic              r_inflight;
    logic [X_W-1:0]    r_pos_x;
    logic [Y_W-1:0]    r_pos_y;
    rgb565_t           r_fg;
    rgb565_t           r_bg;
    logic              r_opaque;
    logic [3:0]        r_rom_sel;

    logic [1:0]        w_count;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_push;
    logic [X_W-1:0]    w_pix_x;
    logic [Y_W-1:0]    w_pix_y;
    logic [ENT_W-1:0]  w_entry;
    logic [ENT_W-1:0]  w_head;

    // Slots that will be occupied next cycle if nothing new is issued.
    assign w_pop   = o_pix_valid && i_pix_ready;
    assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue = (r_state == ST_RUN) && (w_occ < 3'd2);

    // Index layout is {row[3:0], col[2:0]}.
    assign w_push  = r_inflight && (r_opaque || i_rom_q);
    assign w_pix_x = r_pos_x + X_W'(r_if_idx[2:0]);
    assign w_pix_y = r_pos_y + Y_W'(r_if_idx[6:3]);
    assign w_entry = {w_pix_x, w_pix_y, pick_color(i_rom_q, r_fg, r_bg)};

    glyph_pix_fifo #(
        .W(ENT_W)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .o_valid (o_pix_valid),
        .o_data  (w_head),
        .i_ready (i_pix_ready),
        .o_count (w_count)
    );

    assign {o_pix_x, o_pix_y, o_pix_color} = w_head;
    assign o_rom_sel     = r_rom_sel;
    assign o_rom_address = r_idx;

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_issue && (r_idx == LAST_IDX)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                // Leave as soon as the last pixel is being handed off.
                if (!r_inflight && (w_occ == 3'd0)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_if_idx   <= '0;
            r_inflight <= 1'b0;
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_opaque   <= 1'b0;
            r_rom_sel  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_idx <= r_idx;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if ((r_state == ST_IDLE) && i_start) begin
                r_idx     <= '0;
                r_pos_x   <= i_pos_x;
                r_pos_y   <= i_pos_y;
                r_fg      <= i_fg_color;
                r_bg      <= i_bg_color;
                r_opaque  <= i_opaque;
                r_rom_sel <= i_char_code;
            end
        end
    end

endmodule
